// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer placed after the ALU: next-PC selection, the carry flag,
// the branch-target table and the IDLE/RUN/HALTED lifecycle with a retired-instruction count.
module fetch_ctrl #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt_req,
    input  logic             Branch_en,
    input  logic             Zero,
    input  logic             SC_OUT,
    input  logic             Carry_we,
    input  logic [IDX_W-1:0] Target_idx,
    input  logic             Lut_we,
    input  logic [IDX_W-1:0] Lut_addr,
    input  logic [PC_W-1:0]  Lut_data,
    output logic [PC_W-1:0]  PC,
    output logic             SC_FLAG,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] Instr_cnt
);

    localparam int               LUT_DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             sc_q, sc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  lut_q [LUT_DEPTH];

    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the case can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        sc_d    = sc_q;
        cnt_d   = cnt_q;
        case (state_q)
            // Flow-control inputs are only looked at in RUN, so X on them elsewhere cannot reach state.
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    sc_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (Carry_we)         sc_d  = SC_OUT;
                if (Halt_req)                 state_d = S_HALTED;
                else if (Branch_en && Zero)   pc_d    = lut_q[Target_idx];
                else                          pc_d    = pc_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            sc_q    <= 1'b0;
            cnt_q   <= '0;
            // NOTE: the table is a register array that must come up all-zero, so it is reset like any flop.
            for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sc_q    <= sc_d;
            cnt_q   <= cnt_d;
            // The branch read above sees the old entry; the new value lands at this edge.
            if (Lut_we) lut_q[Lut_addr] <= Lut_data;
        end
    end

    assign PC        = pc_q;
    assign SC_FLAG   = sc_q;
    assign Instr_cnt = cnt_q;
    assign Running   = (state_q == S_RUN);
    assign Done      = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural model pushes the expected post-edge outputs
// per cycle, which are popped and compared one edge later, alongside directed constant checks.
module tb_fetch_ctrl;

    localparam int PC_W  = 10;
    localparam int IDX_W = 5;
    localparam int CNT_W = 16;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

    typedef logic [PC_W+CNT_W+2:0] obs_t;

    logic             CLK = 1'b0;
    logic             Reset, Start, Halt_req, Branch_en, Zero, SC_OUT, Carry_we, Lut_we;
    logic [IDX_W-1:0] Target_idx, Lut_addr;
    logic [PC_W-1:0]  Lut_data;
    logic [PC_W-1:0]  PC;
    logic             SC_FLAG, Running, Done;
    logic [CNT_W-1:0] Instr_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    int               m_state;
    logic [PC_W-1:0]  m_pc;
    logic             m_sc;
    logic [CNT_W-1:0] m_cnt;
    logic [PC_W-1:0]  m_lut [1<<IDX_W];
    obs_t             sb_q [$];

    fetch_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Halt_req(Halt_req),
        .Branch_en(Branch_en), .Zero(Zero), .SC_OUT(SC_OUT), .Carry_we(Carry_we),
        .Target_idx(Target_idx), .Lut_we(Lut_we), .Lut_addr(Lut_addr), .Lut_data(Lut_data),
        .PC(PC), .SC_FLAG(SC_FLAG), .Running(Running), .Done(Done), .Instr_cnt(Instr_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t observed();
        return {PC, SC_FLAG, Running, Done, Instr_cnt};
    endfunction

    function automatic obs_t model_view();
        return {m_pc, m_sc, m_state == M_RUN, m_state == M_HALTED, m_cnt};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = '0;
        m_sc    = 1'b0;
        m_cnt   = '0;
        for (int i = 0; i < (1 << IDX_W); i++) m_lut[i] = '0;
        sb_q.delete();
    endtask

    // Advance the model by one edge using the currently driven inputs and queue the expectation.
    task automatic model_step();
        int               n_state = m_state;
        logic [PC_W-1:0]  n_pc    = m_pc;
        logic             n_sc    = m_sc;
        logic [CNT_W-1:0] n_cnt   = m_cnt;
        if (m_state == M_RUN) begin
            n_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (Carry_we === 1'b1) n_sc = SC_OUT;
            if (Halt_req === 1'b1)                         n_state = M_HALTED;
            else if (Branch_en === 1'b1 && Zero === 1'b1)  n_pc = m_lut[Target_idx];
            else                                           n_pc = m_pc + 10'd1;
        end else if (Start === 1'b1) begin
            n_state = M_RUN;
            n_pc    = '0;
            n_sc    = 1'b0;
            n_cnt   = '0;
        end
        if (Lut_we === 1'b1) m_lut[Lut_addr] = Lut_data;
        m_state = n_state;
        m_pc    = n_pc;
        m_sc    = n_sc;
        m_cnt   = n_cnt;
        sb_q.push_back(model_view());
    endtask

    task automatic cycle(input string tag);
        obs_t exp;
        model_step();
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check(tag, 32'(observed()), 32'(exp));
        end
    endtask

    task automatic idle_inputs();
        Start = 0; Halt_req = 0; Branch_en = 0; Zero = 0; SC_OUT = 0; Carry_we = 0;
        Lut_we = 0; Target_idx = '0; Lut_addr = '0; Lut_data = '0;
    endtask

    task automatic lut_write(input logic [IDX_W-1:0] a, input logic [PC_W-1:0] d);
        Lut_we = 1; Lut_addr = a; Lut_data = d;
        cycle($sformatf("lut_wr_%0d", a));
        Lut_we = 0;
    endtask

    task automatic branch(input logic [IDX_W-1:0] idx, input logic z, input string tag);
        Branch_en = 1; Zero = z; Target_idx = idx;
        cycle(tag);
        Branch_en = 0; Zero = 0;
    endtask

    initial begin
        idle_inputs();
        Reset = 1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", 32'(observed()), 32'(model_view()));
        #4 Reset = 0;
        @(posedge CLK); #1;

        // IDLE: unknown flow-control inputs must be ignored while the table is loaded.
        Halt_req = 1'bx; Branch_en = 1'bx; Zero = 1'bx; Carry_we = 1'bx;
        lut_write(5'd3, 10'h2A0);
        lut_write(5'd2, 10'h007);
        lut_write(5'd5, 10'h3FF);
        lut_write(5'd6, 10'h012);
        check("idle_x_running", 32'(Running), 32'd0);
        check("idle_x_pc", 32'(PC), 32'd0);
        idle_inputs();

        // Start and straight-line execution.
        Start = 1; cycle("start"); Start = 0;
        check("start_pc", 32'(PC), 32'd0);
        check("start_running", 32'(Running), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            cycle($sformatf("seq_%0d", i));
            check($sformatf("seq_pc_%0d", i), 32'(PC), 32'(i));
        end
        check("seq_cnt", 32'(Instr_cnt), 32'd5);
        check("seq_done", 32'(Done), 32'd0);

        // Branches, taken and not taken, from PC 7.
        branch(5'd2, 1'b1, "br_to_7");
        check("br_to_7_pc", 32'(PC), 32'h007);
        branch(5'd3, 1'b1, "br_taken");
        check("br_taken_pc", 32'(PC), 32'h2A0);
        branch(5'd2, 1'b1, "br_to_7b");
        branch(5'd3, 1'b0, "br_not_taken");
        check("br_not_taken_pc", 32'(PC), 32'h008);

        // Same-cycle table write and branch to that entry.
        Lut_we = 1; Lut_addr = 5'd3; Lut_data = 10'h155;
        branch(5'd3, 1'b1, "br_wr_same");
        Lut_we = 0;
        check("br_wr_same_pc", 32'(PC), 32'h2A0);
        branch(5'd3, 1'b1, "br_after_wr");
        check("br_after_wr_pc", 32'(PC), 32'h155);

        // Carry flag and halt.
        Carry_we = 1; SC_OUT = 1; cycle("carry_set");
        check("carry_set_sc", 32'(SC_FLAG), 32'd1);
        Carry_we = 0; SC_OUT = 0; cycle("carry_hold");
        check("carry_hold_sc", 32'(SC_FLAG), 32'd1);
        Halt_req = 1; Carry_we = 1; SC_OUT = 0; cycle("halt");
        check("halt_sc", 32'(SC_FLAG), 32'd0);
        check("halt_done", 32'(Done), 32'd1);
        check("halt_pc", 32'(PC), 32'h157);
        check("halt_cnt", 32'(Instr_cnt), 32'd14);
        Halt_req = 1'bx; Branch_en = 1'bx; Zero = 1'bx; Carry_we = 1'bx; SC_OUT = 1;
        for (int i = 0; i < 3; i++) cycle($sformatf("halted_x_%0d", i));
        check("halted_x_pc", 32'(PC), 32'h157);
        idle_inputs();
        Start = 1; cycle("restart"); Start = 0;
        check("restart_pc", 32'(PC), 32'd0);
        check("restart_cnt", 32'(Instr_cnt), 32'd0);
        check("restart_done", 32'(Done), 32'd0);
        Start = 1; cycle("start_in_run"); Start = 0;
        check("start_in_run_pc", 32'(PC), 32'd1);

        // PC wrap and counter saturation.
        branch(5'd5, 1'b1, "br_to_3ff");
        check("br_to_3ff_pc", 32'(PC), 32'h3FF);
        cycle("wrap");
        check("wrap_pc", 32'(PC), 32'h000);
        for (int i = 0; i < 65539; i++) cycle("sat_run");
        check("sat_cnt", 32'(Instr_cnt), 32'hFFFF);

        // Asynchronous reset mid-RUN, with Start held during reset.
        Carry_we = 1; SC_OUT = 1;
        branch(5'd6, 1'b1, "br_to_12");
        Carry_we = 0; SC_OUT = 0;
        check("br_to_12_pc", 32'(PC), 32'h012);
        #2 Reset = 1;
        #1;
        check("async_rst_pc", 32'(PC), 32'd0);
        check("async_rst_running", 32'(Running), 32'd0);
        check("async_rst_sc", 32'(SC_FLAG), 32'd0);
        check("async_rst_cnt", 32'(Instr_cnt), 32'd0);
        Start = 1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_start_ignored", 32'(Running), 32'd0);
        @(negedge CLK);
        Reset = 0; Start = 0;
        model_reset();
        Start = 1; cycle("post_rst_start"); Start = 0;
        branch(5'd3, 1'b1, "br_cleared_lut");
        check("br_cleared_lut_pc", 32'(PC), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
